// File: rtl/nand_gate.sv
// nand_gate: registered, width-parameterised bitwise NAND with a valid-qualified pipeline.
// Define NAND_GATE_COMB_EN to collapse it to a zero-latency combinational gate.

`ifndef NAND_GATE_COMB_EN
// One bit position of the pipeline. Stage 1 loads only on a valid input, so a
// bubble repeats the previous result instead of exposing new (possibly X) data.
module nand_gate_lane #(
    parameter int STAGES = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ld,
    input  logic a,
    input  logic b,
    output logic y
);
    logic [STAGES-1:0] q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '1;
        end else begin
            if (ld) q[0] <= ~(a & b);
            for (int k = 1; k < STAGES; k++) q[k] <= q[k-1];
        end
    end

    assign y = q[STAGES-1];
endmodule
`endif

module nand_gate #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    output logic [WIDTH-1:0] Y,
    output logic             Y_all
);
`ifdef NAND_GATE_COMB_EN
    wire unused_clk_rst = &{1'b0, clk, rst_n};

    assign Y         = ~(A & B);
    assign Y_all     = &Y;
    assign out_valid = in_valid;
`else
    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
        $error("nand_gate: STAGES=%0d outside legal range 1..4", STAGES);
    end

    logic [STAGES:1] vld_pipe;
    logic [STAGES:1] all_pipe;

    // Y_all travels with the data rather than being reduced from Y at the output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            all_pipe <= '1;
        end else begin
            vld_pipe[1] <= in_valid;
            if (in_valid) all_pipe[1] <= &(~(A & B));
            for (int k = 2; k <= STAGES; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
                all_pipe[k] <= all_pipe[k-1];
            end
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        nand_gate_lane #(.STAGES(STAGES)) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .ld    (in_valid),
            .a     (A[i]),
            .b     (B[i]),
            .y     (Y[i])
        );
    end

    assign out_valid = vld_pipe[STAGES];
    assign Y_all     = all_pipe[STAGES];
`endif
endmodule

// File: tb/tb_nand_gate.sv
// Directed-vector bench for nand_gate: four registered configurations sharing one clock,
// or the combinational build when NAND_GATE_COMB_EN is defined.
module tb_nand_gate;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // d1: W1 S1, d3: W8 S3, d2: W8 S2, d4: W4 S4
    logic       v1 = 0, ov1, ya1;
    logic       a1 = 0, b1 = 0, y1;
    logic       v3 = 0, ov3, ya3;
    logic [7:0] a3 = 0, b3 = 0, y3;
    logic       v2 = 0, ov2, ya2;
    logic [7:0] a2 = 0, b2 = 0, y2;
    logic       v4 = 0, ov4, ya4;
    logic [3:0] a4 = 0, b4 = 0, y4;

    nand_gate #(.WIDTH(1), .STAGES(1)) d1 (.clk(clk), .rst_n(rst_n), .in_valid(v1), .A(a1), .B(b1),
                                           .out_valid(ov1), .Y(y1), .Y_all(ya1));
    nand_gate #(.WIDTH(8), .STAGES(3)) d3 (.clk(clk), .rst_n(rst_n), .in_valid(v3), .A(a3), .B(b3),
                                           .out_valid(ov3), .Y(y3), .Y_all(ya3));
    nand_gate #(.WIDTH(8), .STAGES(2)) d2 (.clk(clk), .rst_n(rst_n), .in_valid(v2), .A(a2), .B(b2),
                                           .out_valid(ov2), .Y(y2), .Y_all(ya2));
    nand_gate #(.WIDTH(4), .STAGES(4)) d4 (.clk(clk), .rst_n(rst_n), .in_valid(v4), .A(a4), .B(b4),
                                           .out_valid(ov4), .Y(y4), .Y_all(ya4));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
`ifdef NAND_GATE_COMB_EN
        logic [1:0] ab;
        for (int i = 0; i < 4; i++) begin
            ab = 2'(i);
            a1 = ab[1]; b1 = ab[0]; v1 = ab[0];
            #1;
            chk($sformatf("comb_y_%0d", i), y1, (i == 3) ? 0 : 1);
            chk($sformatf("comb_all_%0d", i), ya1, (i == 3) ? 0 : 1);
            chk($sformatf("comb_ov_%0d", i), ov1, ab[0]);
        end
`else
        logic [1:0] ab;
        // reset, no clock edge yet
        #1 rst_n = 1'b0;
        #1;
        chk("rst_y1", y1, 1);
        chk("rst_all1", ya1, 1);
        chk("rst_ov1", ov1, 0);
        chk("rst_y3", y3, 8'hFF);
        chk("rst_ov3", ov3, 0);
        @(negedge clk) rst_n = 1'b1;

        // W1 S1 truth table back to back
        for (int i = 0; i < 4; i++) begin
            ab = 2'(i);
            v1 = 1; a1 = ab[1]; b1 = ab[0];
            tick();
            chk($sformatf("tt_y_%0d", i), y1, (i == 3) ? 0 : 1);
            chk($sformatf("tt_all_%0d", i), ya1, (i == 3) ? 0 : 1);
            chk($sformatf("tt_ov_%0d", i), ov1, 1);
            @(negedge clk);
        end
        v1 = 0; a1 = 0; b1 = 0;
        tick();
        chk("tt_bubble_ov", ov1, 0);
        chk("tt_bubble_y", y1, 0);
        @(negedge clk);

        // W8 S3 single-pulse latency
        v3 = 1; a3 = 8'hF0; b3 = 8'hCC;
        tick();
        chk("s3_ov_e0", ov3, 0);
        @(negedge clk) v3 = 0; a3 = 8'h00; b3 = 8'h00;
        tick();
        chk("s3_ov_e1", ov3, 0);
        tick();
        chk("s3_ov_e2", ov3, 1);
        chk("s3_y", y3, 8'h3F);
        chk("s3_all", ya3, 0);
        tick();
        chk("s3_ov_e3", ov3, 0);
        chk("s3_y_hold", y3, 8'h3F);
        @(negedge clk);

        // W8 S2: X operands while idle must not reach Y
        v2 = 1; a2 = 8'hFF; b2 = 8'hFF;
        tick();
        chk("s2_ov_e0", ov2, 0);
        @(negedge clk) v2 = 0; a2 = 'x; b2 = 'x;
        tick();
        chk("s2_ov_e1", ov2, 1);
        chk("s2_y_e1", y2, 8'h00);
        chk("s2_all_e1", ya2, 0);
        for (int i = 2; i < 5; i++) begin
            tick();
            chk($sformatf("s2_ov_e%0d", i), ov2, 0);
            chk($sformatf("s2_y_e%0d", i), y2, 8'h00);
        end
        @(negedge clk) a2 = 0; b2 = 0;

        // W4 S4: reset mid-flight discards everything in the pipe
        v4 = 1; a4 = 4'hF; b4 = 4'hF;
        tick();
        @(negedge clk) a4 = 4'h3; b4 = 4'h5;
        tick();
        @(negedge clk) a4 = 4'hC; b4 = 4'h4;
        @(posedge clk) #2 rst_n = 1'b0;
        #1;
        chk("s4_rst_y", y4, 4'hF);
        chk("s4_rst_ov", ov4, 0);
        chk("s4_rst_all", ya4, 1);
        v4 = 0;
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("s4_idle_ov_%0d", i), ov4, 0);
            chk($sformatf("s4_idle_y_%0d", i), y4, 4'hF);
        end
        @(negedge clk) v4 = 1; a4 = 4'h1; b4 = 4'h1;
        tick();
        chk("s4_new_ov_e0", ov4, 0);
        @(negedge clk) v4 = 0; a4 = 0; b4 = 0;
        tick();
        chk("s4_new_ov_e1", ov4, 0);
        tick();
        chk("s4_new_ov_e2", ov4, 0);
        tick();
        chk("s4_new_ov_e3", ov4, 1);
        chk("s4_new_y", y4, 4'hE);
        chk("s4_new_all", ya4, 0);
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
